sb_stream_lane_op: RTL

Parametrised switchboard stream transformer with `valid`/`ready` handshakes on both sides. It applies a runtime-selected per-lane arithmetic operation to the low `NLANES` lanes of each beat and buffers results in a `DEPTH`-entry elastic FIFO. It also keeps beat and packet counters and detects the all-ones end-of-stream beat. It sits between an `sb_rx_sim` and an `sb_tx_sim` port pair in stream testbenches and generalises the fixed "add 42 to bits [63:0]" pass-through.

---
 rtl/sb_stream_lane_op.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sb_stream_lane_op.sv
// Applies pass/add/sub/xor with a runtime operand to the low NLANES lanes of each beat; all-ones beat ends the stream.
// Latency: a beat accepted at edge N is visible on out_* after edge N and poppable at edge N+1 at the earliest.
// Backpressure: in_ready = !full & !done from registered state only; out_ready only controls the pop.

module sb_stream_lane_op #(
  parameter int DW     = 256,
  parameter int LANE_W = 64,
  parameter int NLANES = 1,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [1:0]        op,
  input  logic [LANE_W-1:0] operand,
  input  logic [DW-1:0]     in_data,
  input  logic [31:0]       in_dest,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DW-1:0]     out_data,
  output logic [31:0]       out_dest,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic [31:0]       beat_count,
  output logic [31:0]       pkt_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DW-1:0]     r_mem_data [DEPTH];
  logic [31:0]       r_mem_dest [DEPTH];
  logic              r_mem_last [DEPTH];
  logic              r_done;
  logic [31:0]       r_beat_count;
  logic [31:0]       r_pkt_count;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_is_term;
  logic [DW-1:0]     w_xf_data;
  logic [LANE_W-1:0] w_lane;
  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;

  assign w_wr_idx  = r_wr_ptr[AW-1:0];
  assign w_rd_idx  = r_rd_ptr[AW-1:0];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
  assign w_is_term = &in_data;

  assign in_ready  = !w_full && !r_done;
  assign w_push    = in_valid && in_ready;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  // Head entry is gated by empty so outputs read zero while reset holds the FIFO empty.
  assign out_data   = w_empty ? '0 : r_mem_data[w_rd_idx];
  assign out_dest   = w_empty ? '0 : r_mem_dest[w_rd_idx];
  assign out_last   = w_empty ? 1'b0 : r_mem_last[w_rd_idx];
  assign done       = r_done;
  assign beat_count = r_beat_count;
  assign pkt_count  = r_pkt_count;

  // Per-lane transform; the terminator bypasses it and upper lanes pass through.
  always_comb begin
    w_xf_data = in_data;
    w_lane    = '0;
    if (!w_is_term) begin
      for (int k = 0; k < NLANES; k++) begin
        w_lane = in_data[k*LANE_W +: LANE_W];
        case (op)
          2'd1:    w_lane = w_lane + operand;
          2'd2:    w_lane = w_lane - operand;
          2'd3:    w_lane = w_lane ^ operand;
          default: w_lane = w_lane;
        endcase
        w_xf_data[k*LANE_W +: LANE_W] = w_lane;
      end
    end
  end

  // FIFO storage write; contents are only observed through the empty-gated head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[w_wr_idx] <= w_xf_data;
      r_mem_dest[w_wr_idx] <= in_dest;
      r_mem_last[w_wr_idx] <= in_last;
    end
  end

  // FIFO pointers: push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Sticky end-of-stream flag and wrapping beat/packet counters.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_done       <= 1'b0;
      r_beat_count <= '0;
      r_pkt_count  <= '0;
    end else if (w_push) begin
      r_beat_count <= r_beat_count + 32'd1;
      if (in_last)   r_pkt_count <= r_pkt_count + 32'd1;
      if (w_is_term) r_done <= 1'b1;
    end
  end

endmodule
